psram_req_queue: RTL and testbench
==================================

Name: psram_req_queue

Overview:
- Client-side front end for the existing QPI PSRAM controller.
- Accepts single-word read/write requests over a valid/ready interface and buffers them in a small FIFO.
- Issues requests to the controller one at a time, holding address and data stable for the whole transaction.
- Returns read data to the client with a one-cycle valid pulse and acknowledges writes. Sits directly upstream of the controller.

Parameters:
- DEPTH, 4, request FIFO entries; power of two, minimum 2.
- ADDR_W, 24, word address width; matches the controller address input.
- DATA_W, 16, data width; matches controller data in/out.
- TIMEOUT, 1023, maximum cycles in WAIT_ACK or WAIT_DONE before the error flag sets.

Ports:
- i_clk  in  1  system clock, same clock as the controller.
- i_rst  in  1  synchronous, active-high reset.
- i_req_valid  in  1  client request valid.
- o_req_ready  out  1  FIFO not full.
- i_req_we  in  1  1 = write, 0 = read.
- i_req_addr  in  ADDR_W  request address.
- i_req_wdata  in  DATA_W  write data; ignored for reads.
- o_rsp_valid  out  1  one-cycle pulse, read data valid.
- o_rsp_rdata  out  DATA_W  read data; held until the next read completes.
- o_wr_ack  out  1  one-cycle pulse, write completed.
- o_level  out  $clog2(DEPTH)+1  FIFO occupancy.
- o_err  out  1  sticky timeout flag.
- o_stb  out  1  strobe to controller (i_stb).
- o_we  out  1  to controller i_we.
- o_addr  out  ADDR_W  to controller i_addr.
- o_din  out  DATA_W  to controller i_din.
- i_busy  in  1  controller psram_busy.
- i_done  in  1  controller o_done.
- i_dout  in  DATA_W  controller o_dout.

Behaviour:
- Reset:
  - All outputs are 0 and the FIFO is empty (o_level=0).
  - o_req_ready=1.
  - The FSM goes to INIT.
  - o_err clears only on reset.
- FIFO:
  - Push when i_req_valid && o_req_ready.
  - Pop when the FSM leaves IDLE for ISSUE.
  - A simultaneous push and pop leaves o_level unchanged.
  - When full (o_level==DEPTH), o_req_ready=0 and the request is not accepted.
  - Pointers wrap modulo DEPTH.
  - o_req_ready is registered-free, derived combinationally from o_level.
- FSM states INIT, IDLE, ISSUE, WAIT_ACK, WAIT_DONE:
  - INIT: wait for i_done=1 and i_busy=0 (controller QPI entry complete), then go to IDLE. FIFO pushes are allowed during INIT.
  - IDLE: if the FIFO is non-empty, pop the head into the o_we/o_addr/o_din registers and go to ISSUE.
  - ISSUE: o_stb=1 for exactly this one cycle; go to WAIT_ACK.
  - WAIT_ACK: wait for i_done=0 (controller has accepted the request), then go to WAIT_DONE.
  - WAIT_DONE: wait for i_done=1 and i_busy=0.
    - Read: register i_dout into o_rsp_rdata and pulse o_rsp_valid.
    - Write: pulse o_wr_ack.
    - Go to IDLE.
- o_addr, o_din and o_we stay constant from ISSUE through WAIT_DONE. The controller samples the address nibbles across several cycles, so this is mandatory.
- Back-to-back throughput:
  - IDLE→ISSUE occurs no earlier than the cycle after the WAIT_DONE exit.
  - Minimum gap between o_stb pulses = controller transaction length + 2 cycles.
- Response latency is one cycle after i_done rises; o_rsp_valid and o_wr_ack never assert together.
- Timeout:
  - A cycle counter runs in WAIT_ACK and WAIT_DONE.
  - On reaching TIMEOUT, set o_err, abandon the request with no response pulse, and go to INIT.
  - The counter clears on every state change.
- Reset mid-transaction: o_stb drops immediately, the FIFO is flushed, and no response is generated. The controller has its own reset; after reset INIT re-waits for i_done.

Decomposition:
- Shared package psram_pkg: the FSM state enum (psram_q_state_t), default widths ADDR_W=24 and DATA_W=16, and a packed request struct {we, addr, wdata}.
- Sub-module sync_fifo (parameterised WIDTH, DEPTH; push/pop/full/empty/level) holds the packed request. The FSM and timeout logic stay in the top.

Test Plan:
- Init gating: push a read to 0x000010 while the controller model holds i_done=0 for 50 cycles → no o_stb before i_done=1. o_stb occurs 2 cycles after i_done=1 with o_addr=0x000010.
- Write then read: write 0x00ABCD=0x1234, then read 0x00ABCD → o_wr_ack pulse, then o_rsp_valid with o_rsp_rdata=0x1234. o_addr stays stable through each transaction.
- Full FIFO: push 5 requests with no controller progress, DEPTH=4 → o_level=4 and o_req_ready=0. The fifth request is held until a pop, then accepted; all 5 are issued in order.
- Simultaneous push/pop: push in the same cycle as the IDLE→ISSUE pop with o_level=2 → o_level remains 2 and order is preserved.
- Timeout: the controller never drops i_done after o_stb, TIMEOUT=1023 → o_err=1 after 1023 cycles, no response pulse, FSM back in INIT. o_err persists until i_rst.
- Mid-transaction reset: assert i_rst during WAIT_DONE → the next cycle has o_stb=0, o_level=0, o_req_ready=1, and no o_rsp_valid.

Source files
------------

// File: rtl/psram_pkg.sv
// Shared types and default widths for the PSRAM request queue.
package psram_pkg;

    localparam int PSRAM_ADDR_W = 24;
    localparam int PSRAM_DATA_W = 16;

    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_IDLE      = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DONE = 3'd4
    } psram_q_state_t;

    // Layout of one queued request at the default widths (MSB first: we, addr, wdata).
    typedef struct packed {
        logic                    we;
        logic [PSRAM_ADDR_W-1:0] addr;
        logic [PSRAM_DATA_W-1:0] wdata;
    } psram_req_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-two depth, first-word fall-through read port.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      level_q;
    logic             push_ok, pop_ok;

    assign o_full  = (level_q == (AW+1)'(DEPTH));
    assign o_empty = (level_q == '0);
    assign o_level = level_q;
    assign o_rdata = mem_q[rptr_q];

    assign push_ok = i_push && !o_full;
    assign pop_ok  = i_pop && !o_empty;

    // NOTE: storage has no reset; the level counter alone decides what is valid,
    // so resetting the array would only cost logic.
    always_ff @(posedge i_clk) begin
        if (push_ok) mem_q[wptr_q] <= i_wdata;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + AW'(1);
            if (pop_ok)  rptr_q <= rptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/psram_req_queue.sv
// Client front end for the QPI PSRAM controller: queues single-word requests
// and issues them one at a time, holding address/data stable per transaction.
module psram_req_queue
    import psram_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = PSRAM_ADDR_W,
    parameter int DATA_W  = PSRAM_DATA_W,
    parameter int TIMEOUT = 1023
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic                      i_req_we,
    input  logic [ADDR_W-1:0]         i_req_addr,
    input  logic [DATA_W-1:0]         i_req_wdata,
    output logic                      o_rsp_valid,
    output logic [DATA_W-1:0]         o_rsp_rdata,
    output logic                      o_wr_ack,
    output logic [$clog2(DEPTH):0]    o_level,
    output logic                      o_err,
    output logic                      o_stb,
    output logic                      o_we,
    output logic [ADDR_W-1:0]         o_addr,
    output logic [DATA_W-1:0]         o_din,
    input  logic                      i_busy,
    input  logic                      i_done,
    input  logic [DATA_W-1:0]         i_dout
);
    localparam int REQ_W = 1 + ADDR_W + DATA_W;
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    psram_q_state_t     state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               we_q, rsp_valid_q, wr_ack_q, err_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  din_q, rdata_q;
    logic [REQ_W-1:0]   head;
    logic               fifo_full, fifo_empty;
    logic               push, pop, complete, timeout, cnt_hit;

    assign o_req_ready = (o_level != LVL_W'(DEPTH));
    assign push        = i_req_valid && o_req_ready;
    assign pop         = (state_q == ST_IDLE) && !fifo_empty;
    assign complete    = (state_q == ST_WAIT_DONE) && i_done && !i_busy;
    assign cnt_hit     = (cnt_q == CNT_W'(TIMEOUT - 1));

    sync_fifo #(.WIDTH(REQ_W), .DEPTH(DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_wdata ({i_req_we, i_req_addr, i_req_wdata}),
        .i_pop   (pop),
        .o_rdata (head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_level (o_level)
    );

    // NOTE: every signal driven here gets a default first so no path leaves a latch.
    always_comb begin
        state_d = state_q;
        timeout = 1'b0;
        case (state_q)
            ST_INIT:      if (i_done && !i_busy) state_d = ST_IDLE;
            ST_IDLE:      if (!fifo_empty) state_d = ST_ISSUE;
            ST_ISSUE:     state_d = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (!i_done) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_hit) begin
                    state_d = ST_INIT;
                    timeout = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (i_done && !i_busy) begin
                    state_d = ST_IDLE;
                end else if (cnt_hit) begin
                    state_d = ST_INIT;
                    timeout = 1'b1;
                end
            end
            default:      state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            rsp_valid_q <= 1'b0;
            wr_ack_q    <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            // Counts cycles spent in one wait state; any transition restarts it.
            if (state_d != state_q || (state_q != ST_WAIT_ACK && state_q != ST_WAIT_DONE))
                cnt_q <= '0;
            else
                cnt_q <= cnt_q + CNT_W'(1);
            if (pop) {we_q, addr_q, din_q} <= head;
            rsp_valid_q <= complete && !we_q;
            wr_ack_q    <= complete && we_q;
            if (complete && !we_q) rdata_q <= i_dout;
            if (timeout) err_q <= 1'b1;
        end
    end

    assign o_stb       = (state_q == ST_ISSUE);
    assign o_we        = we_q;
    assign o_addr      = addr_q;
    assign o_din       = din_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = rdata_q;
    assign o_wr_ack    = wr_ack_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_psram_req_queue.sv
// Directed bench for psram_req_queue with a behavioural controller model.
module tb_psram_req_queue;
    import psram_pkg::*;

    localparam int DEPTH   = 4;
    localparam int ADDR_W  = 24;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 1023;

    logic              clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              wr_ack;
    logic [2:0]        level;
    logic              err;
    logic              stb;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] dout;

    int checks = 0;
    int errors = 0;

    // Controller model knobs, written by the main sequence only.
    logic ctl_up = 1'b0;
    logic model_hang = 1'b0;
    int   model_len = 3;

    // Controller model state.
    int                busy_cnt = 0;
    logic              cur_we = 1'b0;
    logic [ADDR_W-1:0] cur_addr = '0;
    logic [DATA_W-1:0] cur_din = '0;
    logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
    logic [ADDR_W-1:0] iss_log [$];

    // Response monitor state.
    int                rsp_cnt = 0;
    int                ack_cnt = 0;
    int                both_cnt = 0;
    int                unstable = 0;
    logic              inflight = 1'b0;
    logic              lat_we = 1'b0;
    logic [ADDR_W-1:0] lat_addr = '0;
    logic [DATA_W-1:0] lat_din = '0;
    logic [DATA_W-1:0] rdata_log [$];

    always #5 clk = ~clk;

    psram_req_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_we    (req_we),
        .i_req_addr  (req_addr),
        .i_req_wdata (req_wdata),
        .o_rsp_valid (rsp_valid),
        .o_rsp_rdata (rsp_rdata),
        .o_wr_ack    (wr_ack),
        .o_level     (level),
        .o_err       (err),
        .o_stb       (stb),
        .o_we        (we),
        .o_addr      (addr),
        .o_din       (din),
        .i_busy      (busy),
        .i_done      (done),
        .i_dout      (dout)
    );

    // Controller: done low/busy high for model_len cycles after each strobe.
    initial begin
        done = 1'b0;
        busy = 1'b1;
        dout = '0;
        forever begin
            @(posedge clk);
            #2;
            if (i_rst) iss_log.delete();
            if (!ctl_up) begin
                done = 1'b0;
                busy = 1'b1;
                busy_cnt = 0;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    if (cur_we) mem[cur_addr] = cur_din;
                    else dout = mem.exists(cur_addr) ? mem[cur_addr] : '0;
                    done = 1'b1;
                    busy = 1'b0;
                end
            end else if (stb) begin
                iss_log.push_back(addr);
                if (!model_hang) begin
                    cur_we = we;
                    cur_addr = addr;
                    cur_din = din;
                    done = 1'b0;
                    busy = 1'b1;
                    busy_cnt = model_len;
                end
            end else begin
                done = 1'b1;
                busy = 1'b0;
            end
        end
    end

    // Counts response pulses and tracks request-signal stability per transaction.
    initial begin
        forever begin
            @(negedge clk);
            if (i_rst) begin
                rsp_cnt = 0;
                ack_cnt = 0;
                both_cnt = 0;
                unstable = 0;
                inflight = 1'b0;
                rdata_log.delete();
            end else begin
                if (rsp_valid) begin
                    rsp_cnt++;
                    rdata_log.push_back(rsp_rdata);
                end
                if (wr_ack) ack_cnt++;
                if (rsp_valid && wr_ack) both_cnt++;
                if (stb) begin
                    inflight = 1'b1;
                    lat_we = we;
                    lat_addr = addr;
                    lat_din = din;
                end else if (inflight) begin
                    if (addr !== lat_addr || we !== lat_we || din !== lat_din) unstable++;
                    if (rsp_valid || wr_ack) inflight = 1'b0;
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input logic up);
        @(posedge clk);
        #1;
        i_rst = 1'b1;
        req_valid = 1'b0;
        ctl_up = up;
        model_hang = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        i_rst = 1'b0;
    endtask

    task automatic push_req(input logic w, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d, output logic ok);
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_we = w;
        req_addr = a;
        req_wdata = d;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (req_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int n, input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (rsp_cnt + ack_cnt >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_stb(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (stb) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        do_reset(1'b0);
        tick();
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        checks++; if ({stb, rsp_valid, wr_ack, err} !== 4'b0) begin errors++; $display("FAIL reset_flags: stb/rsp/ack/err got %b want 0000", {stb, rsp_valid, wr_ack, err}); end
        checks++; if (addr !== '0 || din !== '0 || we !== 1'b0) begin errors++; $display("FAIL reset_bus: addr %h din %h we %b want zeros", addr, din, we); end
        repeat (10) tick();
        checks++; if (dut.state_q !== ST_INIT) begin errors++; $display("FAIL reset_holds_init: state %0d want %0d", dut.state_q, ST_INIT); end
    endtask

    task automatic test_init_gating;
        logic ok;
        int   stb_seen;
        int   first;
        logic [ADDR_W-1:0] first_addr;
        do_reset(1'b0);
        model_len = 3;
        push_req(1'b0, 24'h000010, '0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL init_push: accepted %b want 1", ok); end
        stb_seen = 0;
        repeat (50) begin
            tick();
            if (stb) stb_seen++;
        end
        checks++; if (stb_seen != 0) begin errors++; $display("FAIL init_no_stb: saw %0d strobes want 0", stb_seen); end
        @(posedge clk);
        #1;
        ctl_up = 1'b1;
        first = -1;
        first_addr = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (stb && first < 0) begin
                first = i;
                first_addr = addr;
            end
        end
        checks++; if (first != 2) begin errors++; $display("FAIL init_stb_delay: cycle %0d want 2", first); end
        checks++; if (first_addr !== 24'h000010) begin errors++; $display("FAIL init_stb_addr: got %h want 000010", first_addr); end
        wait_resp(1, 100, ok);
        checks++; if (!ok || rsp_cnt != 1) begin errors++; $display("FAIL init_resp: rsp count %0d want 1", rsp_cnt); end
    endtask

    task automatic test_write_read;
        logic ok;
        logic [DATA_W-1:0] got;
        do_reset(1'b1);
        model_len = 3;
        push_req(1'b1, 24'h00ABCD, 16'h1234, ok);
        push_req(1'b0, 24'h00ABCD, 16'h0000, ok);
        wait_resp(2, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wr_rd_wait: responses %0d want 2", rsp_cnt + ack_cnt); end
        checks++; if (ack_cnt != 1) begin errors++; $display("FAIL wr_rd_ack: got %0d want 1", ack_cnt); end
        checks++; if (rsp_cnt != 1) begin errors++; $display("FAIL wr_rd_rsp: got %0d want 1", rsp_cnt); end
        got = (rdata_log.size() > 0) ? rdata_log[0] : 16'hxxxx;
        checks++; if (got !== 16'h1234) begin errors++; $display("FAIL wr_rd_data: got %h want 1234", got); end
        repeat (5) tick();
        checks++; if (rsp_rdata !== 16'h1234) begin errors++; $display("FAIL wr_rd_hold: got %h want 1234", rsp_rdata); end
        checks++; if (unstable != 0) begin errors++; $display("FAIL wr_rd_stable: %0d unstable cycles want 0", unstable); end
        checks++; if (both_cnt != 0) begin errors++; $display("FAIL wr_rd_exclusive: %0d overlaps want 0", both_cnt); end
    endtask

    task automatic test_full_fifo;
        logic ok;
        logic acc;
        do_reset(1'b0);
        model_len = 3;
        for (int i = 0; i < 4; i++) push_req(i[0], 24'h000100 + 24'(i), 16'h5000 + 16'(i), ok);
        tick();
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_level: got %0d want 4", level); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", req_ready); end
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_we = 1'b0;
        req_addr = 24'h000104;
        repeat (3) tick();
        checks++; if (level !== 3'd4 || req_ready !== 1'b0) begin errors++; $display("FAIL full_held: level %0d ready %b want 4 0", level, req_ready); end
        @(posedge clk);
        #1;
        ctl_up = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (req_ready) begin
                @(posedge clk);
                #1;
                acc = 1'b1;
                break;
            end
        end
        req_valid = 1'b0;
        checks++; if (!acc) begin errors++; $display("FAIL full_fifth_accept: accepted %b want 1", acc); end
        wait_resp(5, 500, ok);
        checks++; if (!ok || iss_log.size() != 5) begin errors++; $display("FAIL full_count: issued %0d want 5", iss_log.size()); end
        for (int i = 0; i < 5 && i < iss_log.size(); i++) begin
            checks++;
            if (iss_log[i] !== 24'h000100 + 24'(i)) begin
                errors++;
                $display("FAIL full_order[%0d]: got %h want %h", i, iss_log[i], 24'h000100 + 24'(i));
            end
        end
    endtask

    task automatic test_push_pop;
        logic ok;
        logic [ADDR_W-1:0] exp_addr [4];
        exp_addr[0] = 24'h000200;
        exp_addr[1] = 24'h000201;
        exp_addr[2] = 24'h000202;
        exp_addr[3] = 24'h000203;
        do_reset(1'b1);
        model_len = 20;
        push_req(1'b1, 24'h000200, 16'hAAAA, ok);
        wait_stb(50, ok);
        push_req(1'b0, 24'h000201, '0, ok);
        push_req(1'b0, 24'h000202, '0, ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (rsp_valid || wr_ack) begin
                ok = 1'b1;
                break;
            end
        end
        checks++; if (!ok || level !== 3'd2) begin errors++; $display("FAIL pp_setup: level %0d want 2", level); end
        // Push lands on the same edge as the IDLE->ISSUE pop.
        req_valid = 1'b1;
        req_we = 1'b0;
        req_addr = 24'h000203;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        tick();
        checks++; if (level !== 3'd2) begin errors++; $display("FAIL pp_level: got %0d want 2", level); end
        checks++; if (stb !== 1'b1 || addr !== 24'h000201) begin errors++; $display("FAIL pp_issue: stb %b addr %h want 1 000201", stb, addr); end
        wait_resp(4, 500, ok);
        checks++; if (!ok || iss_log.size() != 4) begin errors++; $display("FAIL pp_count: issued %0d want 4", iss_log.size()); end
        for (int i = 0; i < 4 && i < iss_log.size(); i++) begin
            checks++;
            if (iss_log[i] !== exp_addr[i]) begin
                errors++;
                $display("FAIL pp_order[%0d]: got %h want %h", i, iss_log[i], exp_addr[i]);
            end
        end
    endtask

    task automatic test_timeout;
        logic ok;
        do_reset(1'b1);
        model_len = 3;
        model_hang = 1'b1;
        push_req(1'b0, 24'h000300, '0, ok);
        wait_stb(50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL to_stb: strobe %b want 1", ok); end
        // 1023 cycles in WAIT_ACK without i_done falling; the error lands on the next edge.
        repeat (TIMEOUT) tick();
        checks++; if (err !== 1'b0 || dut.state_q !== ST_WAIT_ACK) begin errors++; $display("FAIL to_early: err %b state %0d want 0 %0d", err, dut.state_q, ST_WAIT_ACK); end
        tick();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err: got %b want 1", err); end
        checks++; if (dut.state_q !== ST_INIT) begin errors++; $display("FAIL to_state: got %0d want %0d", dut.state_q, ST_INIT); end
        checks++; if (rsp_cnt + ack_cnt != 0) begin errors++; $display("FAIL to_no_resp: got %0d pulses want 0", rsp_cnt + ack_cnt); end
        @(posedge clk);
        #1;
        model_hang = 1'b0;
        push_req(1'b1, 24'h000301, 16'h0BAD, ok);
        wait_resp(1, 200, ok);
        checks++; if (!ok || ack_cnt != 1) begin errors++; $display("FAIL to_recover: acks %0d want 1", ack_cnt); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", err); end
        do_reset(1'b1);
        tick();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_clear: got %b want 0", err); end
    endtask

    task automatic test_mid_reset;
        logic ok;
        int   pulses;
        do_reset(1'b1);
        model_len = 20;
        push_req(1'b0, 24'h000400, '0, ok);
        wait_stb(50, ok);
        push_req(1'b0, 24'h000401, '0, ok);
        push_req(1'b0, 24'h000402, '0, ok);
        tick();
        checks++; if (dut.state_q !== ST_WAIT_DONE || level !== 3'd2) begin errors++; $display("FAIL mr_setup: state %0d level %0d want %0d 2", dut.state_q, level, ST_WAIT_DONE); end
        @(posedge clk);
        #1;
        i_rst = 1'b1;
        ctl_up = 1'b0;
        @(posedge clk);
        #1;
        tick();
        checks++; if (stb !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL mr_outputs: stb %b rsp %b want 0 0", stb, rsp_valid); end
        checks++; if (level !== 3'd0 || req_ready !== 1'b1) begin errors++; $display("FAIL mr_flush: level %0d ready %b want 0 1", level, req_ready); end
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        ctl_up = 1'b1;
        pulses = 0;
        repeat (40) begin
            tick();
            if (rsp_valid || wr_ack || stb) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL mr_quiet: %0d strobes/responses want 0", pulses); end
    endtask

    initial begin
        test_reset();
        test_init_gating();
        test_write_read();
        test_full_fifo();
        test_push_pop();
        test_timeout();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
